// File: rtl/usb_rx_parse.sv
// usb_rx_parse: byte-stream receive parser (55 AA sync hunt, header, payload into RAM, checksum).
// Checksum verification is built only when the USB_RX_CSUM_EN macro is defined.
module usb_rx_parse #(
  parameter logic [11:0] MAX_LEN = 12'h240,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_vld,
  output logic        din_rdy,
  output logic        fs_rx,
  input  logic        fd_rx,
  output logic [3:0]  rx_btype,
  output logic [11:0] rx_len,
  input  logic [11:0] rx_ram_init,
  output logic        ram_we,
  output logic [11:0] ram_waddr,
  output logic [7:0]  ram_wdata,
  output logic [3:0]  dbg_state
);

  // Handshake: a byte transfers on a rising clk edge where din_vld && din_rdy are both 1;
  // din_rdy depends on state only, never on din_vld.
  typedef enum logic [3:0] {
    S_IDLE, S_HEAD1, S_TYPE, S_LENH, S_LENL, S_SYNC, S_DATA, S_CSUM, S_DONE
  } state_t;

  localparam logic [3:0] BAG_ERROR = 4'hF;

  state_t      state;
  logic [11:0] base;
  logic [11:0] idx;
  logic [15:0] gap;
  logic        oversize;
  logic        accept;
  logic        counting;
  logic        tmo;
  logic        csum_bad;
  logic [11:0] len_full;

  assign din_rdy   = (state != S_SYNC) && (state != S_DONE);
  assign accept    = din_vld && din_rdy;
  assign counting  = state inside {S_TYPE, S_LENH, S_LENL, S_DATA, S_CSUM};
  assign tmo       = counting && !accept && (gap == TIMEOUT - 16'd1);
  assign len_full  = {rx_len[11:8], din};
  assign dbg_state = state;

`ifdef USB_RX_CSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= 8'h00;
    end else if (accept) begin
      if (state == S_TYPE) sum <= din;
      else if (state inside {S_LENH, S_LENL, S_DATA}) sum <= sum + din;
    end
  end

  assign csum_bad = (din != sum);
`else
  assign csum_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      fs_rx     <= 1'b0;
      rx_btype  <= 4'h0;
      rx_len    <= 12'h000;
      ram_we    <= 1'b0;
      ram_waddr <= 12'h000;
      ram_wdata <= 8'h00;
      base      <= 12'h000;
      idx       <= 12'h000;
      gap       <= 16'h0000;
      oversize  <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      // The idle-gap counter holds its value while waiting for the sequencer in SYNC.
      if (accept || (!counting && state != S_SYNC)) gap <= 16'h0000;
      else if (counting) gap <= gap + 16'd1;

      case (state)
        S_IDLE: begin
          if (accept && din == 8'h55) state <= S_HEAD1;
        end
        S_HEAD1: begin
          if (accept) begin
            if (din == 8'hAA) state <= S_TYPE;
            else if (din != 8'h55) state <= S_IDLE;
          end
        end
        S_TYPE: begin
          if (accept) begin
            rx_btype <= din[3:0];
            state    <= S_LENH;
          end else if (tmo) begin
            state <= S_IDLE;
          end
        end
        S_LENH: begin
          if (accept) begin
            rx_len[11:8] <= din[3:0];
            state        <= S_LENL;
          end else if (tmo) begin
            state <= S_IDLE;
          end
        end
        S_LENL: begin
          if (accept) begin
            oversize <= (len_full > MAX_LEN);
            if (len_full > MAX_LEN) begin
              rx_btype <= BAG_ERROR;
              rx_len   <= 12'h000;
            end else begin
              rx_len <= len_full;
            end
            fs_rx <= 1'b1;
            state <= S_SYNC;
          end else if (tmo) begin
            state <= S_IDLE;
          end
        end
        S_SYNC: begin
          if (fd_rx) begin
            base <= rx_ram_init;
            idx  <= 12'h000;
            if (oversize) begin
              fs_rx <= 1'b0;
              state <= S_DONE;
            end else if (rx_len == 12'h000) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            ram_we    <= 1'b1;
            ram_waddr <= base + idx;
            ram_wdata <= din;
            idx       <= idx + 12'd1;
            if (idx == rx_len - 12'd1) state <= S_CSUM;
          end else if (tmo) begin
            rx_btype <= BAG_ERROR;
            fs_rx    <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (csum_bad) rx_btype <= BAG_ERROR;
            fs_rx <= 1'b0;
            state <= S_DONE;
          end else if (tmo) begin
            rx_btype <= BAG_ERROR;
            fs_rx    <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (!fd_rx) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
